// File: rtl/icache_dataram_sched.sv
// Single-ported icache data-RAM scheduler: reads first, buffered linefill writes with
// bounded starvation and RAW blocking, credited response FIFO. Option: ICACHE_DRAM_BYPASS_EN.
module icache_dataram_sched #(
    parameter int WAY_NUM         = 2,
    parameter int INDEX_WIDTH     = 7,
    parameter int TXNID_WIDTH     = 5,
    parameter int ENTRY_IDX_WIDTH = 3,
    parameter int LINE_WIDTH      = 512,
    parameter int WBUF_DEPTH      = 2,
    parameter int STARVE_MAX      = 4,
    localparam int WAY_W          = $clog2(WAY_NUM),
    localparam int ADDR_W         = WAY_W + INDEX_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rd_vld_i,
    output logic                       rd_rdy_o,
    input  logic [WAY_W-1:0]           rd_way_i,
    input  logic [INDEX_WIDTH-1:0]     rd_index_i,
    input  logic [TXNID_WIDTH-1:0]     rd_txnid_i,
    input  logic                       wr_vld_i,
    output logic                       wr_rdy_o,
    input  logic [WAY_W-1:0]           wr_way_i,
    input  logic [INDEX_WIDTH-1:0]     wr_index_i,
    input  logic [LINE_WIDTH-1:0]      wr_data_i,
    input  logic [ENTRY_IDX_WIDTH-1:0] wr_entry_idx_i,
    output logic                       ram_en_o,
    output logic                       ram_we_o,
    output logic [ADDR_W-1:0]          ram_addr_o,
    output logic [LINE_WIDTH-1:0]      ram_wdata_o,
    input  logic [LINE_WIDTH-1:0]      ram_rdata_i,
    output logic                       rsp_vld_o,
    input  logic                       rsp_rdy_i,
    output logic [LINE_WIDTH-1:0]      rsp_data_o,
    output logic [TXNID_WIDTH-1:0]     rsp_txnid_o,
    output logic                       wr_done_vld_o,
    output logic [ENTRY_IDX_WIDTH-1:0] wr_done_idx_o
);

    localparam int PTR_W = $clog2(WBUF_DEPTH);
    localparam int STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_MAX);

    logic                       ready_q;
    logic [WBUF_DEPTH-1:0]      wb_vld_q, wb_vld_d;
    logic [PTR_W-1:0]           wb_wptr_q, wb_rptr_q;
    logic [ADDR_W-1:0]          wb_addr_q  [WBUF_DEPTH];
    logic [ENTRY_IDX_WIDTH-1:0] wb_entry_q [WBUF_DEPTH];
    logic [LINE_WIDTH-1:0]      wb_data_q  [WBUF_DEPTH];
    logic [STV_W-1:0]           starve_q, starve_d;
    logic [1:0]                 credit_q, credit_d;

    logic                       pend_q;
    logic [TXNID_WIDTH-1:0]     pend_txnid_q;
    logic [LINE_WIDTH-1:0]      rq_data_q  [2];
    logic [TXNID_WIDTH-1:0]     rq_txnid_q [2];
    logic [1:0]                 rq_cnt_q, rq_cnt_d;
    logic                       rq_wptr_q, rq_rptr_q;
    logic                       done_vld_q;
    logic [ENTRY_IDX_WIDTH-1:0] done_idx_q;

    logic [ADDR_W-1:0]          rd_addr;
    logic [LINE_WIDTH-1:0]      in_data;
    logic wb_empty, wb_full, wb_push, hazard, rd_block, write_forced;
    logic rd_acc, rd_byp, wr_issue;
    logic rq_nonempty, rsp_pop, rq_push, rq_pop;

    assign rd_addr  = {rd_way_i, rd_index_i};
    assign wb_empty = !wb_vld_q[wb_rptr_q];
    assign wb_full  = wb_vld_q[wb_wptr_q];

`ifdef ICACHE_DRAM_BYPASS_EN
    logic [PTR_W-1:0]      byp_sel;
    logic                  pend_byp_q;
    logic [LINE_WIDTH-1:0] pend_bdata_q;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        hazard = 1'b0;
`ifdef ICACHE_DRAM_BYPASS_EN
        byp_sel = wb_rptr_q;
`endif
        // Scan oldest to youngest so the last match is the youngest entry.
        for (int k = 0; k < WBUF_DEPTH; k++) begin
            if (wb_vld_q[wb_rptr_q + PTR_W'(k)] && wb_addr_q[wb_rptr_q + PTR_W'(k)] == rd_addr) begin
                hazard = 1'b1;
`ifdef ICACHE_DRAM_BYPASS_EN
                byp_sel = wb_rptr_q + PTR_W'(k);
`endif
            end
        end
    end

`ifdef ICACHE_DRAM_BYPASS_EN
    assign rd_block = 1'b0;
    assign rd_byp   = rd_acc && hazard;
    assign in_data  = pend_byp_q ? pend_bdata_q : ram_rdata_i;
`else
    assign rd_block = hazard;
    assign rd_byp   = 1'b0;
    assign in_data  = ram_rdata_i;
`endif

    assign write_forced = !wb_empty && (wb_full || starve_q == STV_MAX || rd_block ||
                                        !rd_vld_i || credit_q == 2'd0);
    assign rd_acc   = ready_q && rd_vld_i && credit_q != 2'd0 && !rd_block && !write_forced;
    // A forwarded read leaves the RAM port free for the head write.
    assign wr_issue = !wb_empty && (!rd_acc || rd_byp);
    assign wb_push  = wr_vld_i && wr_rdy_o;

    assign rd_rdy_o    = rd_acc;
    assign wr_rdy_o    = ready_q && !wb_full;
    assign ram_en_o    = (rd_acc && !rd_byp) || wr_issue;
    assign ram_we_o    = wr_issue;
    assign ram_addr_o  = wr_issue ? wb_addr_q[wb_rptr_q] : rd_addr;
    assign ram_wdata_o = wb_data_q[wb_rptr_q];

    always_comb begin
        wb_vld_d = wb_vld_q;
        if (wr_issue) wb_vld_d[wb_rptr_q] = 1'b0;
        if (wb_push)  wb_vld_d[wb_wptr_q] = 1'b1;
        starve_d = starve_q;
        if (wb_empty || wr_issue)            starve_d = '0;
        else if (rd_acc && starve_q != STV_MAX) starve_d = starve_q + 1'b1;
    end

    // Response path flows through when empty so a read can respond at T+1.
    assign rq_nonempty = rq_cnt_q != 2'd0;
    assign rsp_vld_o   = rq_nonempty || pend_q;
    assign rsp_data_o  = rq_nonempty ? rq_data_q[rq_rptr_q] : in_data;
    assign rsp_txnid_o = rq_nonempty ? rq_txnid_q[rq_rptr_q] : pend_txnid_q;
    assign rsp_pop     = rsp_vld_o && rsp_rdy_i;
    assign rq_push     = pend_q && !(!rq_nonempty && rsp_rdy_i);
    assign rq_pop      = rsp_pop && rq_nonempty;
    assign rq_cnt_d    = rq_cnt_q + 2'(rq_push) - 2'(rq_pop);
    assign credit_d    = credit_q + 2'(rsp_pop) - 2'(rd_acc);

    assign wr_done_vld_o = done_vld_q;
    assign wr_done_idx_o = done_idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q      <= 1'b0;
            wb_vld_q     <= '0;
            wb_wptr_q    <= '0;
            wb_rptr_q    <= '0;
            starve_q     <= '0;
            credit_q     <= 2'd2;
            pend_q       <= 1'b0;
            pend_txnid_q <= '0;
            rq_cnt_q     <= '0;
            rq_wptr_q    <= 1'b0;
            rq_rptr_q    <= 1'b0;
            done_vld_q   <= 1'b0;
            done_idx_q   <= '0;
`ifdef ICACHE_DRAM_BYPASS_EN
            pend_byp_q   <= 1'b0;
`endif
        end else begin
            ready_q    <= 1'b1;
            wb_vld_q   <= wb_vld_d;
            wb_wptr_q  <= wb_wptr_q + PTR_W'(wb_push);
            wb_rptr_q  <= wb_rptr_q + PTR_W'(wr_issue);
            starve_q   <= starve_d;
            credit_q   <= credit_d;
            pend_q     <= rd_acc;
            rq_cnt_q   <= rq_cnt_d;
            rq_wptr_q  <= rq_wptr_q ^ rq_push;
            rq_rptr_q  <= rq_rptr_q ^ rq_pop;
            done_vld_q <= wr_issue;
            if (wr_issue) done_idx_q   <= wb_entry_q[wb_rptr_q];
            if (rd_acc)   pend_txnid_q <= rd_txnid_i;
`ifdef ICACHE_DRAM_BYPASS_EN
            pend_byp_q <= rd_byp;
`endif
        end
    end

    // NOTE: payload storage is qualified by valid bits/counters, so it carries no reset.
    always_ff @(posedge clk) begin
        if (wb_push) begin
            wb_addr_q[wb_wptr_q]  <= {wr_way_i, wr_index_i};
            wb_entry_q[wb_wptr_q] <= wr_entry_idx_i;
            wb_data_q[wb_wptr_q]  <= wr_data_i;
        end
        if (rq_push) begin
            rq_data_q[rq_wptr_q]  <= in_data;
            rq_txnid_q[rq_wptr_q] <= pend_txnid_q;
        end
`ifdef ICACHE_DRAM_BYPASS_EN
        if (rd_byp) pend_bdata_q <= wb_data_q[byp_sel];
`endif
    end

endmodule
